sprite_frame_latch: RTL and testbench

//  Parametrised per-sprite state register between game logic and drawcon, generalising the single

---
 rtl/sprite_frame_latch.sv | 164 ++++++++++++++++
 tb/tb_sprite_frame_latch.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_frame_latch.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_frame_latch
//  Purpose  : Per-sprite position/direction register between game logic and
//             drawcon. Writes land in a shadow bank at any time; the shadow
//             bank is copied to the display bank only on frame_start, so the
//             drawer never sees a half-updated frame. One-hot directions are
//             re-encoded to the GUI code, and each sprite runs a walk
//             animation phase that only advances while the sprite moves.
//  Revision : 1.0  initial release
// ============================================================================
module sprite_frame_latch #(
   parameter int NUM_SPR     = 5,
   parameter int X_W         = 11,
   parameter int Y_W         = 10,
   parameter int ANIM_DIV    = 8,
   parameter int ANIM_FRAMES = 4,
   localparam int ID_W       = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1,
   localparam int PH_W       = $clog2(ANIM_FRAMES)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      upd_valid,
   output logic                      upd_ready,
   input  logic [ID_W-1:0]           upd_id,
   input  logic [X_W-1:0]            upd_x,
   input  logic [Y_W-1:0]            upd_y,
   input  logic [3:0]                upd_dir,
   input  logic                      frame_start,
   input  logic                      freeze,
   output logic [NUM_SPR*X_W-1:0]    disp_x,
   output logic [NUM_SPR*Y_W-1:0]    disp_y,
   output logic [NUM_SPR*4-1:0]      disp_dir,
   output logic [NUM_SPR*PH_W-1:0]   anim_phase,
   output logic                      upd_err
);

   // Frame divider width and terminal values
   localparam int              c_div_w    = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
   localparam logic [c_div_w-1:0] c_div_last = c_div_w'(ANIM_DIV - 1);
   localparam logic [PH_W-1:0]    c_ph_last  = PH_W'(ANIM_FRAMES - 1);
   localparam logic [PH_W-1:0]    c_ph_one   = PH_W'(1);
   localparam logic [c_div_w-1:0] c_div_one  = c_div_w'(1);

   // GUI direction codes {rot[2:0], mirror}
   localparam logic [3:0] c_code_right = 4'b0000;
   localparam logic [3:0] c_code_left  = 4'b0011;
   localparam logic [3:0] c_code_up    = 4'b0101;
   localparam logic [3:0] c_code_down  = 4'b0111;

   logic                  w_commit;
   logic                  w_accept;
   logic                  w_step;
   logic                  w_id_ok;
   logic                  w_dir_ok;
   logic [3:0]            w_dir_code;
   logic [c_div_w-1:0]    r_div;
   logic                  r_upd_err;

   // A commit cycle is the only time writers are stalled, so the shadow bank
   // is guaranteed stable on the edge where it is copied to the display bank.
   assign w_commit  = rst & frame_start & ~freeze;
   assign upd_ready = rst & ~(frame_start & ~freeze);
   assign w_accept  = upd_valid & upd_ready;
   assign w_id_ok   = ({{(32-ID_W){1'b0}}, upd_id} < 32'(NUM_SPR));
   assign w_step    = w_commit & (r_div == c_div_last);
   assign upd_err   = r_upd_err;

   // Re-encode the one-hot direction; anything else is flagged as invalid
   always_comb begin
      w_dir_code = c_code_right;
      w_dir_ok   = 1'b0;
      case (upd_dir)
         4'b0001: begin w_dir_code = c_code_right; w_dir_ok = 1'b1; end
         4'b0010: begin w_dir_code = c_code_up;    w_dir_ok = 1'b1; end
         4'b0100: begin w_dir_code = c_code_down;  w_dir_ok = 1'b1; end
         4'b1000: begin w_dir_code = c_code_left;  w_dir_ok = 1'b1; end
         default: begin w_dir_code = c_code_right; w_dir_ok = 1'b0; end
      endcase
   end

   // Frame divider: counts commits and wraps every ANIM_DIV commits
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_div <= '0;
      end else if (w_commit) begin
         if (r_div == c_div_last) begin
            r_div <= '0;
         end else begin
            r_div <= r_div + c_div_one;
         end
      end
   end

   // Error pulse for an accepted write with a bad id or a non-one-hot direction
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_upd_err <= 1'b0;
      end else begin
         r_upd_err <= w_accept & (~w_id_ok | ~w_dir_ok);
      end
   end

   generate
      for (genvar i = 0; i < NUM_SPR; i++) begin : g_spr
         logic [X_W-1:0]  r_sh_x;
         logic [Y_W-1:0]  r_sh_y;
         logic [3:0]      r_sh_dir;
         logic [X_W-1:0]  r_dp_x;
         logic [Y_W-1:0]  r_dp_y;
         logic [3:0]      r_dp_dir;
         logic [PH_W-1:0] r_phase;
         logic            w_wr_en;
         logic            w_moved;

         assign w_wr_en = w_accept & w_id_ok & (upd_id == ID_W'(i));
         // Movement is judged on position only; turning in place is not a step
         assign w_moved = (r_sh_x != r_dp_x) | (r_sh_y != r_dp_y);

         // Shadow entry: position always taken, direction only when valid
         always_ff @(posedge clk) begin
            if (!rst) begin
               r_sh_x   <= '0;
               r_sh_y   <= '0;
               r_sh_dir <= c_code_right;
            end else if (w_wr_en) begin
               r_sh_x <= upd_x;
               r_sh_y <= upd_y;
               if (w_dir_ok) begin
                  r_sh_dir <= w_dir_code;
               end
            end
         end

         // Display entry and walk phase: both change only on a commit
         always_ff @(posedge clk) begin
            if (!rst) begin
               r_dp_x   <= '0;
               r_dp_y   <= '0;
               r_dp_dir <= c_code_right;
               r_phase  <= '0;
            end else if (w_commit) begin
               r_dp_x   <= r_sh_x;
               r_dp_y   <= r_sh_y;
               r_dp_dir <= r_sh_dir;
               if (w_step && w_moved) begin
                  if (r_phase == c_ph_last) begin
                     r_phase <= '0;
                  end else begin
                     r_phase <= r_phase + c_ph_one;
                  end
               end
            end
         end

         assign disp_x[i*X_W +: X_W]        = r_dp_x;
         assign disp_y[i*Y_W +: Y_W]        = r_dp_y;
         assign disp_dir[i*4 +: 4]          = r_dp_dir;
         assign anim_phase[i*PH_W +: PH_W]  = r_phase;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sprite_frame_latch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sprite_frame_latch
//  Purpose  : Self-checking bench for sprite_frame_latch. A stimulus process
//             drives directed and random traffic and pushes the expected
//             outputs of each clock edge into a queue; a monitor process pops
//             and compares them against the design outputs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sprite_frame_latch;

   localparam int NUM_SPR     = 5;
   localparam int X_W         = 11;
   localparam int Y_W         = 10;
   localparam int ANIM_DIV    = 8;
   localparam int ANIM_FRAMES = 4;
   localparam int ID_W        = 3;
   localparam int PH_W        = 2;

   logic                     clk;
   logic                     rst;
   logic                     upd_valid;
   logic                     upd_ready;
   logic [ID_W-1:0]          upd_id;
   logic [X_W-1:0]           upd_x;
   logic [Y_W-1:0]           upd_y;
   logic [3:0]               upd_dir;
   logic                     frame_start;
   logic                     freeze;
   logic [NUM_SPR*X_W-1:0]   disp_x;
   logic [NUM_SPR*Y_W-1:0]   disp_y;
   logic [NUM_SPR*4-1:0]     disp_dir;
   logic [NUM_SPR*PH_W-1:0]  anim_phase;
   logic                     upd_err;

   sprite_frame_latch #(
      .NUM_SPR     (NUM_SPR),
      .X_W         (X_W),
      .Y_W         (Y_W),
      .ANIM_DIV    (ANIM_DIV),
      .ANIM_FRAMES (ANIM_FRAMES)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .upd_valid   (upd_valid),
      .upd_ready   (upd_ready),
      .upd_id      (upd_id),
      .upd_x       (upd_x),
      .upd_y       (upd_y),
      .upd_dir     (upd_dir),
      .frame_start (frame_start),
      .freeze      (freeze),
      .disp_x      (disp_x),
      .disp_y      (disp_y),
      .disp_dir    (disp_dir),
      .anim_phase  (anim_phase),
      .upd_err     (upd_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [NUM_SPR*X_W-1:0]  x;
      logic [NUM_SPR*Y_W-1:0]  y;
      logic [NUM_SPR*4-1:0]    dir;
      logic [NUM_SPR*PH_W-1:0] ph;
      logic                    err;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Reference state: integers and plain arrays
   int m_sh_x[NUM_SPR], m_sh_y[NUM_SPR], m_sh_dir[NUM_SPR];
   int m_dp_x[NUM_SPR], m_dp_y[NUM_SPR], m_dp_dir[NUM_SPR];
   int m_ph[NUM_SPR];
   int m_commits;
   int m_err;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // GUI code table from the direction description; -1 for invalid input
   function automatic int gui_code(input logic [3:0] d);
      if (d == 4'b0001) return 0;
      if (d == 4'b1000) return 3;
      if (d == 4'b0010) return 5;
      if (d == 4'b0100) return 7;
      return -1;
   endfunction

   // Advance the reference by one clock edge with the given inputs
   task automatic model_edge(input bit r, input bit v, input int id, input int x, input int y,
                             input logic [3:0] d, input bit fs, input bit fz);
      bit commit, accept;
      if (!r) begin
         for (int i = 0; i < NUM_SPR; i++) begin
            m_sh_x[i] = 0; m_sh_y[i] = 0; m_sh_dir[i] = 0;
            m_dp_x[i] = 0; m_dp_y[i] = 0; m_dp_dir[i] = 0; m_ph[i] = 0;
         end
         m_commits = 0;
         m_err = 0;
         return;
      end
      commit = fs && !fz;
      accept = v && !commit;
      if (commit) begin
         // Every ANIM_DIV-th commit is an animation step
         m_commits++;
         for (int i = 0; i < NUM_SPR; i++) begin
            if ((m_commits % ANIM_DIV == 0) &&
                (m_sh_x[i] != m_dp_x[i] || m_sh_y[i] != m_dp_y[i]))
               m_ph[i] = (m_ph[i] + 1) % ANIM_FRAMES;
            m_dp_x[i] = m_sh_x[i]; m_dp_y[i] = m_sh_y[i]; m_dp_dir[i] = m_sh_dir[i];
         end
      end
      m_err = 0;
      if (accept) begin
         if (id < NUM_SPR) begin
            m_sh_x[id] = x; m_sh_y[id] = y;
            if (gui_code(d) >= 0) m_sh_dir[id] = gui_code(d);
            else m_err = 1;
         end else begin
            m_err = 1;
         end
      end
   endtask

   // Apply one cycle of inputs, check ready, and queue the expected outputs
   task automatic drive(input bit r, input bit v, input int id, input int x, input int y,
                        input logic [3:0] d, input bit fs, input bit fz);
      exp_t e;
      @(negedge clk);
      rst = r; upd_valid = v; upd_id = ID_W'(id); upd_x = X_W'(x); upd_y = Y_W'(y);
      upd_dir = d; frame_start = fs; freeze = fz;
      #1;
      chk("upd_ready", {63'd0, upd_ready}, {63'd0, (r && !(fs && !fz))});
      model_edge(r, v, id, x, y, d, fs, fz);
      for (int i = 0; i < NUM_SPR; i++) begin
         e.x[i*X_W +: X_W]    = X_W'(m_dp_x[i]);
         e.y[i*Y_W +: Y_W]    = Y_W'(m_dp_y[i]);
         e.dir[i*4 +: 4]      = 4'(m_dp_dir[i]);
         e.ph[i*PH_W +: PH_W] = PH_W'(m_ph[i]);
      end
      e.err = (m_err != 0);
      exp_q.push_back(e);
   endtask

   task automatic idle();
      drive(1, 0, 0, 0, 0, 4'b0001, 0, 0);
   endtask
   task automatic write(input int id, input int x, input int y, input logic [3:0] d);
      drive(1, 1, id, x, y, d, 0, 0);
   endtask
   task automatic frame();
      drive(1, 0, 0, 0, 0, 4'b0001, 1, 0);
   endtask
   task automatic settle();
      @(posedge clk);
      #3;
   endtask

   // Monitor: after every edge compare design outputs to the queued expectation
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("disp_x",     {9'd0,  disp_x},     {9'd0,  e.x});
            chk("disp_y",     {14'd0, disp_y},     {14'd0, e.y});
            chk("disp_dir",   {44'd0, disp_dir},   {44'd0, e.dir});
            chk("anim_phase", {54'd0, anim_phase}, {54'd0, e.ph});
            chk("upd_err",    {63'd0, upd_err},    {63'd0, e.err});
         end
      end
   end

   // Stimulus
   initial begin
      rst = 1'b0; upd_valid = 1'b0; upd_id = '0; upd_x = '0; upd_y = '0;
      upd_dir = 4'b0001; frame_start = 1'b0; freeze = 1'b0;

      // Reset, with a frame_start during reset: reset wins
      drive(0, 1, 2, 5, 5, 4'b0001, 1, 0);
      drive(0, 0, 0, 0, 0, 4'b0001, 0, 0);
      settle();
      chk("reset_disp_x", {9'd0, disp_x}, 64'd0);
      chk("reset_phase", {54'd0, anim_phase}, 64'd0);

      // Write is invisible until the next commit
      write(2, 40, 25, 4'b1000);
      idle(); idle();
      settle();
      chk("spr2_x_before_commit", {53'd0, disp_x[2*X_W +: X_W]}, 64'd0);
      frame();
      settle();
      chk("spr2_x_after_commit", {53'd0, disp_x[2*X_W +: X_W]}, 64'd40);
      chk("spr2_y_after_commit", {54'd0, disp_y[2*Y_W +: Y_W]}, 64'd25);
      chk("spr2_dir_after_commit", {60'd0, disp_dir[2*4 +: 4]}, 64'd3);

      // Non-one-hot direction: error, direction kept, position taken
      write(1, 7, 9, 4'b0110);
      settle();
      chk("err_bad_dir", {63'd0, upd_err}, 64'd1);
      frame();
      settle();
      chk("spr1_dir_kept", {60'd0, disp_dir[1*4 +: 4]}, 64'd0);
      chk("spr1_x_taken", {53'd0, disp_x[1*X_W +: X_W]}, 64'd7);

      // Bad id, then a write offered on a commit cycle
      write(7, 99, 99, 4'b0001);
      settle();
      chk("err_bad_id", {63'd0, upd_err}, 64'd1);
      drive(1, 1, 3, 100, 100, 4'b0001, 1, 0);
      idle();
      frame();
      settle();
      chk("spr3_write_not_taken", {53'd0, disp_x[3*X_W +: X_W]}, 64'd0);

      // Animation: sprite 0 moves every frame, sprite 3 stays put
      drive(0, 0, 0, 0, 0, 4'b0001, 0, 0);
      drive(0, 0, 0, 0, 0, 4'b0001, 0, 0);
      for (int f = 1; f <= 32; f++) begin
         write(0, f, 3, 4'b0001);
         frame();
         if (f == 16) begin
            settle();
            chk("phase0_after16", {62'd0, anim_phase[0 +: PH_W]}, 64'd2);
            chk("phase3_after16", {62'd0, anim_phase[3*PH_W +: PH_W]}, 64'd0);
         end
      end
      settle();
      chk("phase0_after32", {62'd0, anim_phase[0 +: PH_W]}, 64'd0);

      // Freeze holds the display bank while writes keep landing in the shadow
      write(4, 50, 60, 4'b0010);
      for (int k = 1; k <= 3; k++) begin
         drive(1, 1, 4, 50 + k, 60, 4'b0010, 1, 1);
      end
      settle();
      chk("spr4_frozen", {53'd0, disp_x[4*X_W +: X_W]}, 64'd0);
      frame();
      settle();
      chk("spr4_unfrozen_x", {53'd0, disp_x[4*X_W +: X_W]}, 64'd53);
      chk("spr4_unfrozen_dir", {60'd0, disp_dir[4*4 +: 4]}, 64'd5);

      // Randomised traffic against the reference
      for (int n = 0; n < 3000; n++) begin
         logic [3:0] d;
         int sel;
         sel = int'($urandom_range(0, 9));
         case (sel)
            0: d = 4'($urandom_range(0, 15));
            1, 2: d = 4'b0001;
            3, 4: d = 4'b0010;
            5, 6: d = 4'b0100;
            default: d = 4'b1000;
         endcase
         drive(($urandom_range(0, 199) != 0),
               ($urandom_range(0, 9) < 7),
               int'($urandom_range(0, 7)),
               int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)),
               d,
               ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 5) == 0));
      end

      idle();
      repeat (3) settle();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
